// File: rtl/spi_debug_host.sv
// spi_debug_host
//   SPI initiator for the debug link, host side. It serialises 16-bit words
//   LSB first. An address word is preceded by IDLE_CLOCKS spi_clk pulses with
//   CS high, which tells the far end that the next word is an address. Data
//   words that follow are written at consecutive addresses. Once CS has gone
//   low it stays low; only a new address preamble or reset raises it again.
//
// Parameters
//   CLK_DIV      clk cycles per spi_clk half-period (>= 1)
//   IDLE_CLOCKS  spi_clk pulses with CS high before an address word (>= 1)
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; a word moves on valid & ready
//   cmd_addr              1 = address word (opens a transaction), 0 = data word
//   cmd_data[15:0]        word to send
//   spi_clk_o             SPI clock, idles low
//   spi_cs_o              chip select, active low
//   spi_data_o            serial data, stable across every spi_clk rising edge
//   busy                  high while a preamble or word is being shifted
//   err                   one-cycle pulse when a data word arrives with no
//                         transaction open and is dropped
module spi_debug_host #(
    parameter int CLK_DIV     = 4,
    parameter int IDLE_CLOCKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        spi_clk_o,
    output logic        spi_cs_o,
    output logic        spi_data_o,
    output logic        busy,
    output logic        err
);

    localparam int DIV_W   = $clog2(CLK_DIV) + 1;
    localparam int PULSE_W = $clog2(IDLE_CLOCKS) + 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(IDLE_CLOCKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_SHIFT
    } state_e;

    state_e               state_q, state_d;
    logic                 sclk_q, sclk_d;
    logic                 cs_q, cs_d;
    logic                 sdata_q, sdata_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 open_q, open_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           bit_q, bit_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    logic [15:0]          shreg_q, shreg_d;

    // Last cycle of the current spi_clk half-period.
    logic div_end;
    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every _d starts from its _q (err from 0) so no path through the
        // case statement leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        sdata_d = sdata_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        open_d  = open_q;
        div_d   = div_q;
        bit_d   = bit_q;
        pulse_d = pulse_q;
        shreg_d = shreg_q;

        case (state_q)
            S_IDLE: begin
                sclk_d  = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (cmd_valid && ready_q) begin
                    if (cmd_addr) begin
                        // Address: raise CS (if low) and clock the preamble.
                        state_d = S_PRE;
                        cs_d    = 1'b1;
                        sdata_d = 1'b0;
                        shreg_d = cmd_data;
                        div_d   = '0;
                        pulse_d = '0;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                    end else if (open_q) begin
                        // Data inside an open transaction: bit 0 goes out now.
                        state_d = S_SHIFT;
                        sdata_d = cmd_data[0];
                        shreg_d = cmd_data;
                        div_d   = '0;
                        bit_d   = '0;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        // No transaction to write into: drop the word.
                        err_d = 1'b1;
                    end
                end
            end

            S_PRE: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) begin
                    sclk_d = ~sclk_q;
                    // A falling edge completes one preamble pulse.
                    if (sclk_q) begin
                        if (pulse_q == PULSE_LAST) begin
                            state_d = S_SHIFT;
                            cs_d    = 1'b0;
                            open_d  = 1'b1;
                            sdata_d = shreg_q[0];
                            bit_d   = '0;
                            pulse_d = '0;
                        end else begin
                            pulse_d = pulse_q + 1'b1;
                        end
                    end
                end
            end

            S_SHIFT: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) begin
                    sclk_d = ~sclk_q;
                    // Data moves only on the falling edge, so it is stable
                    // across the following rising edge.
                    if (sclk_q) begin
                        bit_d = bit_q + 1'b1;  // wraps 15 -> 0 at word end
                        if (bit_q == 4'd15) begin
                            state_d = S_IDLE;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            sdata_d = shreg_q[1];
                            shreg_d = {1'b0, shreg_q[15:1]};
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            sdata_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            open_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            pulse_q <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            sdata_q <= sdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            open_q  <= open_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            pulse_q <= pulse_d;
            shreg_q <= shreg_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign spi_clk_o  = sclk_q;
    assign spi_cs_o   = cs_q;
    assign spi_data_o = sdata_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_spi_debug_host.sv
// tb_spi_debug_host
//   Directed bench for spi_debug_host (CLK_DIV = 2, IDLE_CLOCKS = 1).
//   A timeline model predicts every output on every cycle from the accept
//   cycle of each command; a pin-level receiver decodes the SPI stream into
//   address/data writes; directed literal checks pin the model.
module tb_spi_debug_host;

    localparam int D = 2;  // CLK_DIV
    localparam int I = 1;  // IDLE_CLOCKS

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_addr = 1'b0;
    logic [15:0] cmd_data = 16'h0000;
    logic        cmd_ready;
    logic        spi_clk_o;
    logic        spi_cs_o;
    logic        spi_data_o;
    logic        busy;
    logic        err;

    spi_debug_host #(.CLK_DIV(D), .IDLE_CLOCKS(I)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .spi_clk_o  (spi_clk_o),
        .spi_cs_o   (spi_cs_o),
        .spi_data_o (spi_data_o),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Timeline model: each command fixes the output waveform as a function
    // of the number of cycles since it was accepted.
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic        m_rst_prev = 1'b1;
    int          m_kind = 0;       // 0 none, 1 data word, 2 address word
    int          m_start = 0;
    int          m_end = 0;
    int          m_err_cyc = -1;
    logic [15:0] m_word = 16'h0000;
    logic        m_open = 1'b0;
    logic        m_idle_cs = 1'b1;
    logic        m_idle_data = 1'b0;

    always @(negedge clk) begin : model
        logic [5:0] exp_v;
        logic [5:0] act_v;
        int         e;
        if (m_rst_prev) begin
            m_kind      = 0;
            m_open      = 1'b0;
            m_idle_cs   = 1'b1;
            m_idle_data = 1'b0;
            m_err_cyc   = -1;
            exp_v       = 6'b010000;
        end else begin
            if (m_kind != 0 && cyc >= m_end) begin
                m_open      = 1'b1;
                m_idle_cs   = 1'b0;
                m_idle_data = m_word[15];
                m_kind      = 0;
            end
            if (m_kind != 0) begin
                e = cyc - m_start;
                if (m_kind == 2 && e < 2 * I * D) begin
                    exp_v = {((e / D) % 2) == 1, 1'b1, 1'b0, 3'b010};
                end else begin
                    if (m_kind == 2) e = e - 2 * I * D;
                    exp_v = {((e / D) % 2) == 1, 1'b0, m_word[e / (2 * D)], 3'b010};
                end
            end else begin
                exp_v = {1'b0, m_idle_cs, m_idle_data, 1'b1, 1'b0, cyc == m_err_cyc};
            end
        end
        act_v = {spi_clk_o, spi_cs_o, spi_data_o, cmd_ready, busy, err};
        check("cycle {clk,cs,data,ready,busy,err}", act_v, exp_v);
        if (!reset && cmd_valid && exp_v[2]) begin
            if (cmd_addr) begin
                m_kind  = 2;
                m_start = cyc + 1;
                m_end   = cyc + 1 + (2 * I + 32) * D;
                m_word  = cmd_data;
            end else if (m_open) begin
                m_kind  = 1;
                m_start = cyc + 1;
                m_end   = cyc + 1 + 32 * D;
                m_word  = cmd_data;
            end else begin
                m_err_cyc = cyc + 1;
            end
        end
        m_rst_prev = reset;
        cyc++;
    end

    // ------------------------------------------------------------------
    // Pin-level receiver: the far end of the link, plus edge statistics.
    // ------------------------------------------------------------------
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    int          rise_cnt = 0;
    int          pre_rise_cnt = 0;
    int          cs_rise_cnt = 0;
    int          run = 0;
    int          run_d_cnt = 0;
    int          run_d1_cnt = 0;
    int          run_other_cnt = 0;
    logic        rx_addr_next = 1'b0;
    int          rx_bits = 0;
    logic [15:0] rx_shift = 16'h0000;
    logic [15:0] rx_addr = 16'h0000;
    logic        samples[$];
    logic [31:0] writes[$];

    always @(negedge clk) begin : receiver
        if (spi_cs_o && !prev_cs) cs_rise_cnt++;
        if (spi_clk_o && !prev_sclk) begin
            rise_cnt++;
            if (run == D) run_d_cnt++;
            else if (run == D + 1) run_d1_cnt++;
            else run_other_cnt++;
            run = 0;
            if (spi_cs_o) begin
                pre_rise_cnt++;
                rx_addr_next = 1'b1;
                rx_bits      = 0;
            end else begin
                samples.push_back(spi_data_o);
                rx_shift = {spi_data_o, rx_shift[15:1]};
                rx_bits++;
                if (rx_bits == 16) begin
                    rx_bits = 0;
                    if (rx_addr_next) begin
                        rx_addr      = rx_shift;
                        rx_addr_next = 1'b0;
                    end else begin
                        writes.push_back({rx_addr, rx_shift});
                        rx_addr = rx_addr + 16'd1;
                    end
                end
            end
        end else if (!spi_clk_o && (!spi_cs_o || busy)) begin
            run++;
        end else begin
            run = 0;
        end
        prev_sclk = spi_clk_o;
        prev_cs   = spi_cs_o;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max_cycles, output int waited);
        waited = 0;
        while (!cmd_ready && waited < max_cycles) begin
            tick();
            waited++;
        end
        if (!cmd_ready) check("cmd_ready before timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic send(input logic a, input logic [15:0] w, input bit hold);
        int waited;
        cmd_addr  = a;
        cmd_data  = w;
        cmd_valid = 1'b1;
        wait_ready(500, waited);
        tick();
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int waited;
        int r0, p0, c0, s0, w0, d0, d10, o0;
        int exp_seq[16] = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0};

        // Reset held for three cycles.
        reset = 1'b1;
        repeat (3) tick();
        check("reset spi_cs_o", {31'd0, spi_cs_o}, 32'd1);
        check("reset spi_clk_o", {31'd0, spi_clk_o}, 32'd0);
        check("reset spi_data_o", {31'd0, spi_data_o}, 32'd0);
        check("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("cmd_ready first cycle after reset", {31'd0, cmd_ready}, 32'd1);

        // Data word with no open transaction is dropped.
        r0 = rise_cnt;
        send(1'b0, 16'hBEEF, 1'b0);
        check("err after dropped word", {31'd0, err}, 32'd1);
        check("cmd_ready after dropped word", {31'd0, cmd_ready}, 32'd1);
        tick();
        check("err one cycle only", {31'd0, err}, 32'd0);
        repeat (5) tick();
        check("no spi_clk edge on dropped word", rise_cnt - r0, 32'd0);
        check("cs unchanged on dropped word", {31'd0, spi_cs_o}, 32'd1);

        // Address word 0x1234.
        p0 = pre_rise_cnt;
        s0 = samples.size();
        send(1'b1, 16'h1234, 1'b0);
        wait_ready(200, waited);
        check("cycles from address accept to cmd_ready", waited + 1, 32'd69);
        check("preamble pulses with CS high", pre_rise_cnt - p0, 32'd1);
        check("bits sampled for 0x1234", samples.size() - s0, 32'd16);
        if (samples.size() >= s0 + 16) begin
            for (int i = 0; i < 16; i++)
                check($sformatf("0x1234 bit %0d", i), {31'd0, samples[s0 + i]}, exp_seq[i]);
        end
        check("cs low after address word", {31'd0, spi_cs_o}, 32'd0);
        check("no write from address alone", writes.size(), 32'd0);

        // Back-to-back: address 0x0100, data 0xAAAA, 0x5555, valid held high.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        r0  = rise_cnt;
        c0  = cs_rise_cnt;
        d0  = run_d_cnt;
        d10 = run_d1_cnt;
        o0  = run_other_cnt;
        w0  = writes.size();
        send(1'b1, 16'h0100, 1'b1);
        send(1'b0, 16'hAAAA, 1'b1);
        send(1'b0, 16'h5555, 1'b0);
        wait_ready(200, waited);
        check("total spi_clk rising edges", rise_cnt - r0, I + 48);
        check("cs never rises in back-to-back", cs_rise_cnt - c0, 32'd0);
        check("low phases of CLK_DIV+1 cycles", run_d1_cnt - d10, 32'd2);
        check("low phases of CLK_DIV cycles", run_d_cnt - d0, 32'd47);
        check("low phases of other lengths", run_other_cnt - o0, 32'd0);
        check("writes decoded by receiver", writes.size() - w0, 32'd2);
        if (writes.size() >= w0 + 2) begin
            check("write 0 {addr,data}", writes[w0], 32'h0100_AAAA);
            check("write 1 {addr,data}", writes[w0 + 1], 32'h0101_5555);
        end

        // Reset while bit 7 of a data word is on the line.
        r0 = rise_cnt;
        send(1'b0, 16'h0F0F, 1'b0);
        waited = 0;
        while (rise_cnt - r0 < 7 && waited < 200) begin
            tick();
            waited++;
        end
        check("seven bits clocked before reset", rise_cnt - r0, 32'd7);
        tick();
        check("cs low mid-word", {31'd0, spi_cs_o}, 32'd0);
        reset = 1'b1;
        tick();
        check("cs after mid-word reset", {31'd0, spi_cs_o}, 32'd1);
        check("spi_clk after mid-word reset", {31'd0, spi_clk_o}, 32'd0);
        check("busy after mid-word reset", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();
        send(1'b0, 16'h0F0F, 1'b0);
        check("err on data word after reset", {31'd0, err}, 32'd1);

        // Receiver resynchronises on the next preamble.
        w0 = writes.size();
        send(1'b1, 16'h0200, 1'b1);
        send(1'b0, 16'h1357, 1'b0);
        wait_ready(200, waited);
        check("writes after resync", writes.size() - w0, 32'd1);
        if (writes.size() >= w0 + 1)
            check("resync write {addr,data}", writes[w0], 32'h0200_1357);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_debug_host.md
# spi_debug_host

SPI initiator that drives the debug SPI link from the host side: it serialises 16-bit address and data words, LSB first, onto spi_clk/spi_cs/spi_data for the debug write port on the far end. An address word opens a transaction by clocking the link with CS high, which marks the next word as an address. Data words that follow are written at consecutive addresses. The block sits in the host or bridge FPGA and runs entirely in one clock domain, generating spi_clk by division.

## Interface
- CLK_DIV, 4: clk cycles per spi_clk half-period; must be ≥1.
- IDLE_CLOCKS, 2: spi_clk pulses issued with CS high before an address word; must be ≥1.
- clk  in  1  system clock; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a command word is presented.
- cmd_ready  out  1  the block can accept a command; a word transfers when cmd_valid & cmd_ready.
- cmd_addr  in  1  1 = address word (opens a new transaction); 0 = data word.
- cmd_data  in  16  word to send.
- spi_clk_o  out  1  SPI clock; idles low.
- spi_cs_o  out  1  chip select, active low.
- spi_data_o  out  1  serial data; the far end samples it on the spi_clk rising edge.
- busy  out  1  high while a word or CS preamble is being shifted.
- err  out  1  one-cycle pulse when a data word is dropped.

## Operation
- Internal flag open: 1 while a transaction is open (CS held low).
- IDLE state:
  - spi_clk_o = 0; CS stays at its current level.
  - cmd_ready = 1, busy = 0.
  - On accept with cmd_addr = 1: latch cmd_data and go to PRE.
  - On accept with cmd_addr = 0 and open = 1: latch cmd_data and go to SHIFT.
  - On accept with cmd_addr = 0 and open = 0: drop the word, pulse err for one cycle, stay in IDLE. spi_* outputs do not change.
- PRE state:
  - spi_cs_o = 1, spi_data_o = 0.
  - Issue IDLE_CLOCKS spi_clk pulses; each pulse is CLK_DIV cycles low, then CLK_DIV cycles high.
  - Then set spi_cs_o = 0, set open = 1, and go to SHIFT.
- SHIFT state:
  - 16 bits, bit 0 first.
  - Each bit is CLK_DIV cycles low, then CLK_DIV cycles high.
  - spi_data_o changes only in the cycle spi_clk_o falls (or at entry to SHIFT), so data is stable across each rising edge.
  - After the high phase of bit 15, drive spi_clk_o = 0 and return to IDLE.
  - CS stays low and open stays 1.
- No command closes a transaction; CS rises only in PRE or on reset.
- Counters:
  - Divider: clog2(CLK_DIV)+1 bits.
  - Bit counter: 4 bits, wraps 15→0 at the end of a word.
  - Pulse counter: clog2(IDLE_CLOCKS)+1 bits.

## Timing
- Reset values (held during reset, taking effect on the first clk after reset rises):
  - spi_clk_o = 0, spi_cs_o = 1, spi_data_o = 0.
  - cmd_ready = 0, busy = 0, err = 0, open = 0, state IDLE.
  - cmd_ready = 1 in the first cycle after reset deasserts.
- Data word accepted at cycle T:
  - T+1: cmd_ready = 0, busy = 1, spi_data_o = bit 0, spi_clk_o = 0.
  - First rising edge at T+1+CLK_DIV.
  - Bit n is valid over [T+1+2n·CLK_DIV, T+1+(2n+2)·CLK_DIV).
  - At T+1+32·CLK_DIV: spi_clk_o = 0, cmd_ready = 1, busy = 0.
- Address word accepted at cycle T:
  - CS is high from T+1 (it rises at T+1 if it was low).
  - spi_cs_o falls and bit 0 is driven at T+1+2·IDLE_CLOCKS·CLK_DIV.
  - cmd_ready returns at T+1+(2·IDLE_CLOCKS+32)·CLK_DIV.
- Back-to-back commands: the next word may be accepted in the same cycle cmd_ready returns. The low phase between words is then CLK_DIV+1 cycles; there is no other gap.
- err is asserted at T+1 for a dropped word; cmd_ready stays 1.
- Reset mid-word or mid-PRE: outputs go to their reset values on the next clk and the partial word is abandoned. The far end resynchronises on the next PRE.

## Test plan
- Reset: assert reset for 3 cycles → spi_cs_o = 1, spi_clk_o = 0, spi_data_o = 0, cmd_ready = 0. After release, cmd_ready = 1 on the first cycle.
- Address word, CLK_DIV = 2, IDLE_CLOCKS = 1, send 0x1234 → exactly 1 spi_clk pulse with CS high, then CS low. 16 rising edges sample 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0. cmd_ready returns 69 cycles after acceptance.
- Data word with no open transaction, sent after reset (0xBEEF) → err high for exactly 1 cycle; no spi_clk edge and no CS change.
- Back-to-back: address 0x0100, then data 0xAAAA and 0x5555, with cmd_valid held high → CS stays low across both data words. The inter-word low phase is CLK_DIV+1 cycles. Total spi_clk rising edges = IDLE_CLOCKS + 48.
- Reset asserted at bit 7 of a data word → on the next clk spi_cs_o = 1 and spi_clk_o = 0, and open is cleared. A following data word produces err.
- End-to-end with the debug SPI slave as the receiver model: address 0x0100, then data 0xAAAA and 0x5555 → the receiver issues writes of 0xAAAA to 0x0100 and 0x5555 to 0x0101.
